dlatch_ift: RTL and testbench

- Clock-sampled 2-bit D-latch with information-flow tracking (IFT).
- Alongside the data path, every signal carries a 32-bit taint label: a bitmask of taint sources that may influence that signal.
- The block propagates taint from D and EN into Q so that downstream IFT logic can track data flow through storage elements.
- Used as the tracked replacement for a plain enable-latch in instrumented netlists.

---
 rtl/ift_pkg.sv | 14 +
 rtl/dlatch_ift_if.sv | 23 ++
 rtl/ift_ctrl_taint.sv | 20 ++
 rtl/dlatch_ift.sv | 52 +++++
 tb/tb_dlatch_ift.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/ift_pkg.sv
// rtl/ift_pkg.sv - shared taint-label types and helpers for IFT-instrumented logic
package ift_pkg;

   localparam int unsigned TAINT_W = 32;

   typedef logic [TAINT_W-1:0] taint_t;

   localparam taint_t taint_none = '0;

   function automatic taint_t taint_join(input taint_t a, input taint_t b);
      return a | b;
   endfunction

endpackage

// File: rtl/dlatch_ift_if.sv
// rtl/dlatch_ift_if.sv - data/taint bundle between a tracked latch and its driver
interface dlatch_ift_if #(
   parameter int unsigned DATA_W = 2
) ();

   logic [DATA_W-1:0]  D;
   ift_pkg::taint_t    D_t;
   logic               EN;
   ift_pkg::taint_t    EN_t;
   logic [DATA_W-1:0]  Q;
   ift_pkg::taint_t    Q_t;

   modport master (
      output D, D_t, EN, EN_t,
      input  Q, Q_t
   );

   modport slave (
      input  D, D_t, EN, EN_t,
      output Q, Q_t
   );

endinterface

// File: rtl/ift_ctrl_taint.sv
// rtl/ift_ctrl_taint.sv - taint contributed by a control input to a storage element
module ift_ctrl_taint
   import ift_pkg::*;
#(
   parameter int unsigned DATA_W  = 2,
   parameter bit          PRECISE = 1'b1
) (
   input  taint_t            en_t_i,
   input  logic [DATA_W-1:0] d_i,
   input  logic [DATA_W-1:0] q_i,
   output taint_t            ctrl_t_o
);

   // In precise mode the enable is only observable when it selects between differing values.
   logic ctrl_matters;

   assign ctrl_matters = (PRECISE == 1'b0) || (d_i != q_i);
   assign ctrl_t_o     = ctrl_matters ? en_t_i : taint_none;

endmodule

// File: rtl/dlatch_ift.sv
// rtl/dlatch_ift.sv - clock-sampled enable latch with taint propagation into Q_t
module dlatch_ift
   import ift_pkg::*;
#(
   parameter int unsigned DATA_W  = 2,
   parameter bit          PRECISE = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   dlatch_ift_if.slave   bus
);

   logic [DATA_W-1:0] q_q;
   logic [DATA_W-1:0] q_d;
   taint_t            q_t_q;
   taint_t            q_t_d;
   taint_t            ctrl_t;

   ift_ctrl_taint #(
      .DATA_W  (DATA_W),
      .PRECISE (PRECISE)
   ) u_ctrl_taint (
      .en_t_i   (bus.EN_t),
      .d_i      (bus.D),
      .q_i      (q_q),
      .ctrl_t_o (ctrl_t)
   );

   // A load replaces the stale label; a hold accumulates control taint on top of it.
   always_comb begin
      q_d   = q_q;
      q_t_d = taint_join(q_t_q, ctrl_t);
      if (bus.EN) begin
         q_d   = bus.D;
         q_t_d = taint_join(bus.D_t, ctrl_t);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= '0;
         q_t_q <= taint_none;
      end else begin
         q_q   <= q_d;
         q_t_q <= q_t_d;
      end
   end

   assign bus.Q   = q_q;
   assign bus.Q_t = q_t_q;

endmodule

// File: tb/tb_dlatch_ift.sv
// tb/tb_dlatch_ift.sv - scoreboard bench for dlatch_ift in conservative and precise modes
module tb_dlatch_ift;
   import ift_pkg::*;

   typedef struct packed {
      logic [1:0] q;
      taint_t     t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] d;
   taint_t     dt;
   taint_t     et;

   int checks = 0;
   int errors = 0;

   exp_t exp_c_q[$];
   exp_t exp_p_q[$];

   logic [1:0] mq_c, mq_p;
   taint_t     mt_c, mt_p;

   always #5 clk = ~clk;

   dlatch_ift_if #(.DATA_W(2)) bus_c ();
   dlatch_ift_if #(.DATA_W(2)) bus_p ();

   assign bus_c.D    = d;
   assign bus_c.D_t  = dt;
   assign bus_c.EN   = en;
   assign bus_c.EN_t = et;
   assign bus_p.D    = d;
   assign bus_p.D_t  = dt;
   assign bus_p.EN   = en;
   assign bus_p.EN_t = et;

   dlatch_ift #(.DATA_W(2), .PRECISE(1'b0)) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (bus_c.slave)
   );

   dlatch_ift #(.DATA_W(2), .PRECISE(1'b1)) dut_p (
      .clk (clk),
      .rst (rst),
      .bus (bus_p.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic en_v, input logic [1:0] d_v, input taint_t dt_v, input taint_t et_v);
      taint_t ctl_c, ctl_p;
      exp_t   e;
      @(negedge clk);
      en = en_v;
      d  = d_v;
      dt = dt_v;
      et = et_v;
      ctl_c = et_v;
      ctl_p = (d_v != mq_p) ? et_v : 32'h0;
      if (en_v) begin
         mq_c = d_v;  mt_c = dt_v | ctl_c;
         mq_p = d_v;  mt_p = dt_v | ctl_p;
      end else begin
         mt_c = mt_c | ctl_c;
         mt_p = mt_p | ctl_p;
      end
      exp_c_q.push_back('{q: mq_c, t: mt_c});
      exp_p_q.push_back('{q: mq_p, t: mt_p});
      @(posedge clk);
      #1;
      if (exp_c_q.size() == 0) chk("sb_c_empty", 64'd0, 64'd1);
      else begin
         e = exp_c_q.pop_front();
         chk("c_q",  {62'd0, bus_c.Q}, {62'd0, e.q});
         chk("c_qt", {32'd0, bus_c.Q_t}, {32'd0, e.t});
      end
      if (exp_p_q.size() == 0) chk("sb_p_empty", 64'd0, 64'd1);
      else begin
         e = exp_p_q.pop_front();
         chk("p_q",  {62'd0, bus_p.Q}, {62'd0, e.q});
         chk("p_qt", {32'd0, bus_p.Q_t}, {32'd0, e.t});
      end
   endtask

   // Reset asserted between edges must clear both instances before any edge arrives.
   task automatic rst_pulse();
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_c_q",  {62'd0, bus_c.Q},   64'd0);
      chk("rst_c_qt", {32'd0, bus_c.Q_t}, 64'd0);
      chk("rst_p_q",  {62'd0, bus_p.Q},   64'd0);
      chk("rst_p_qt", {32'd0, bus_p.Q_t}, 64'd0);
      mq_c = 2'b00; mt_c = 32'h0;
      mq_p = 2'b00; mt_p = 32'h0;
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      d   = 2'b00;
      dt  = 32'h0;
      et  = 32'h0;
      mq_c = 2'b00; mt_c = 32'h0;
      mq_p = 2'b00; mt_p = 32'h0;
      #2;
      chk("init_c_q",  {62'd0, bus_c.Q},   64'd0);
      chk("init_c_qt", {32'd0, bus_c.Q_t}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0);
      chk("pre_rst_qt", {32'd0, bus_c.Q_t}, 64'h0000_0000_FFFF_FFFF);
      rst_pulse();

      step(1'b1, 2'b10, 32'h1, 32'h0);
      chk("load_q",  {62'd0, bus_c.Q},   64'd2);
      chk("load_qt", {32'd0, bus_c.Q_t}, 64'h1);

      step(1'b1, 2'b01, 32'h0, 32'h0);
      step(1'b0, 2'b11, 32'h0, 32'h2);
      chk("hold_q",  {62'd0, bus_c.Q},   64'd1);
      chk("hold_qt", {32'd0, bus_c.Q_t}, 64'h2);
      step(1'b0, 2'b11, 32'h0, 32'h4);
      chk("hold_acc_qt", {32'd0, bus_c.Q_t}, 64'h6);

      step(1'b1, 2'b00, 32'h0, 32'h0);
      step(1'b0, 2'b00, 32'h0, 32'h8);
      chk("prune_qt",  {32'd0, bus_p.Q_t}, 64'h0);
      chk("cons_qt",   {32'd0, bus_c.Q_t}, 64'h8);
      step(1'b0, 2'b01, 32'h0, 32'h8);
      chk("unprune_qt", {32'd0, bus_p.Q_t}, 64'h8);

      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 8; i++) begin
            step((i % 2) == 0, 2'(i / 2),
                 (pass == 0) ? 32'h1 : 32'h0,
                 (pass == 0) ? 32'h2 : 32'h0);
            if (pass == 0 && (i % 2) == 0)
               chk("sweep_load_qt", {32'd0, bus_c.Q_t}, 64'h3);
            if (pass == 1 && i == 0)
               chk("sweep_clear_qt", {32'd0, bus_c.Q_t}, 64'h0);
         end
      end

      @(negedge clk);
      en = 1'b1; d = 2'b10; dt = 32'h5; et = 32'h0;
      rst_pulse();
      step(1'b1, 2'b10, 32'h5, 32'h0);
      chk("reload_q",  {62'd0, bus_p.Q},   64'd2);
      chk("reload_qt", {32'd0, bus_p.Q_t}, 64'h5);

      step(1'b0, 2'b01, 32'h0, 32'hFFFF_FFFF);
      step(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("ones_qt", {32'd0, bus_c.Q_t}, 64'h0000_0000_FFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
